decode_execute_reg: RTL

DECODE_EXECUTE_REG -- requirements
Module: decode_execute_reg

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/decode_execute_reg_if.sv | 58 +++++
 rtl/wb_bypass.sv | 30 +++
 rtl/decode_execute_reg.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared CPU types and constants for the decode/execute boundary.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Register 15 holds the PC; its read value comes from the PC logic and
    // must never be replaced by a writeback bypass.
    localparam logic [3:0] PC_REG = 4'd15;

    // Largest value the flush bubble counter can reach before it saturates.
    localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

    // Decoded control bundle, 16 bits. An all-zero bundle is a NOP: nothing
    // is written, nothing branches and the flags are left alone.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [2:0] alu_control;
        logic [1:0] flags_write;
        logic [3:0] cond;
        logic [1:0] imm_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/decode_execute_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_execute_reg_if
// Brief    : Decode-side inputs, writeback port and execute-stage outputs of
//            the decode/execute pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
interface decode_execute_reg_if;
    import cpu_pkg::*;

    // Pipeline control
    logic        stall;
    logic        flush;

    // Decode stage
    logic        valid_d;
    logic [3:0]  ra1_d;
    logic [3:0]  ra2_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic [3:0]  wa3_d;
    logic [31:0] extimm_d;
    ctrl_t       ctrl_d;

    // Writeback port (same signals that drive the register-file write port)
    logic        we3_w;
    logic [3:0]  wa3_w;
    logic [31:0] wd3_w;

    // Execute stage
    logic        valid_e;
    logic [3:0]  ra1_e;
    logic [3:0]  ra2_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [3:0]  wa3_e;
    logic [31:0] extimm_e;
    ctrl_t       ctrl_e;
    logic [15:0] bubble_cnt;

    modport master (
        output stall, flush,
        output valid_d, ra1_d, ra2_d, rd1_d, rd2_d, wa3_d, extimm_d, ctrl_d,
        output we3_w, wa3_w, wd3_w,
        input  valid_e, ra1_e, ra2_e, rd1_e, rd2_e, wa3_e, extimm_e, ctrl_e,
        input  bubble_cnt
    );

    modport slave (
        input  stall, flush,
        input  valid_d, ra1_d, ra2_d, rd1_d, rd2_d, wa3_d, extimm_d, ctrl_d,
        input  we3_w, wa3_w, wd3_w,
        output valid_e, ra1_e, ra2_e, rd1_e, rd2_e, wa3_e, extimm_e, ctrl_e,
        output bubble_cnt
    );

endinterface
`default_nettype wire

// File: rtl/wb_bypass.sv
`default_nettype none
// ============================================================================
// Module   : wb_bypass
// Brief    : Combinational writeback bypass for one source operand. Replaces
//            the read data with the writeback data when the writeback port
//            targets the same register (never the PC register).
// Revision : 1.0 - initial release
// ============================================================================
module wb_bypass
    import cpu_pkg::*;
(
    input  wire logic        en_i,
    input  wire logic [3:0]  ra_i,
    input  wire logic [31:0] rd_i,
    input  wire logic        we3_w_i,
    input  wire logic [3:0]  wa3_w_i,
    input  wire logic [31:0] wd3_w_i,
    output logic [31:0]      rd_o
);

    logic hit;

    // Match compare, then select between register-file data and writeback.
    always_comb begin
        hit  = en_i && we3_w_i && (wa3_w_i == ra_i) && (ra_i != PC_REG);
        rd_o = hit ? wd3_w_i : rd_i;
    end

endmodule
`default_nettype wire

// File: rtl/decode_execute_reg.sv
`default_nettype none
// ============================================================================
// Module   : decode_execute_reg
// Brief    : Decode-to-execute pipeline register with stall, flush (bubble
//            insertion with a saturating bubble counter) and writeback bypass
//            both on capture and while an entry is held by a stall.
// Revision : 1.0 - initial release
// ============================================================================
module decode_execute_reg
    import cpu_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             reset,
    decode_execute_reg_if.slave   bus
);

    // Execute-stage entry state
    logic        valid_e_q,  valid_e_d;
    logic [3:0]  ra1_e_q,    ra1_e_d;
    logic [3:0]  ra2_e_q,    ra2_e_d;
    logic [31:0] rd1_e_q,    rd1_e_d;
    logic [31:0] rd2_e_q,    rd2_e_d;
    logic [3:0]  wa3_e_q,    wa3_e_d;
    logic [31:0] extimm_e_q, extimm_e_d;
    ctrl_t       ctrl_e_q,   ctrl_e_d;
    logic [15:0] bubble_q,   bubble_d;

    // Bypass operand selection: on capture the decode operands are checked,
    // while stalled the held entry's operands are checked instead so a
    // stalled instruction still sees results retiring under it.
    logic        byp_en;
    logic [3:0]  byp_ra1;
    logic [3:0]  byp_ra2;
    logic [31:0] byp_rd1_in;
    logic [31:0] byp_rd2_in;
    logic [31:0] byp_rd1;
    logic [31:0] byp_rd2;

    // Pick which operands feed the bypass units.
    always_comb begin
        byp_en     = bus.stall ? valid_e_q : 1'b1;
        byp_ra1    = bus.stall ? ra1_e_q   : bus.ra1_d;
        byp_ra2    = bus.stall ? ra2_e_q   : bus.ra2_d;
        byp_rd1_in = bus.stall ? rd1_e_q   : bus.rd1_d;
        byp_rd2_in = bus.stall ? rd2_e_q   : bus.rd2_d;
    end

    wb_bypass u_bypass_src1 (
        .en_i    (byp_en),
        .ra_i    (byp_ra1),
        .rd_i    (byp_rd1_in),
        .we3_w_i (bus.we3_w),
        .wa3_w_i (bus.wa3_w),
        .wd3_w_i (bus.wd3_w),
        .rd_o    (byp_rd1)
    );

    wb_bypass u_bypass_src2 (
        .en_i    (byp_en),
        .ra_i    (byp_ra2),
        .rd_i    (byp_rd2_in),
        .we3_w_i (bus.we3_w),
        .wa3_w_i (bus.wa3_w),
        .wd3_w_i (bus.wd3_w),
        .rd_o    (byp_rd2)
    );

    // Next-entry selection: flush beats stall, stall beats capture.
    always_comb begin
        valid_e_d  = valid_e_q;
        ra1_e_d    = ra1_e_q;
        ra2_e_d    = ra2_e_q;
        rd1_e_d    = rd1_e_q;
        rd2_e_d    = rd2_e_q;
        wa3_e_d    = wa3_e_q;
        extimm_e_d = extimm_e_q;
        ctrl_e_d   = ctrl_e_q;
        bubble_d   = bubble_q;

        if (bus.flush) begin
            valid_e_d  = 1'b0;
            ra1_e_d    = '0;
            ra2_e_d    = '0;
            rd1_e_d    = '0;
            rd2_e_d    = '0;
            wa3_e_d    = '0;
            extimm_e_d = '0;
            ctrl_e_d   = CTRL_NOP;
            if (bubble_q != BUBBLE_MAX) begin
                bubble_d = bubble_q + 16'd1;
            end
        end else if (bus.stall) begin
            rd1_e_d = byp_rd1;
            rd2_e_d = byp_rd2;
        end else begin
            // An invalid decode slot still carries its data fields, but its
            // control is forced to NOP so it cannot have side effects.
            valid_e_d  = bus.valid_d;
            ra1_e_d    = bus.ra1_d;
            ra2_e_d    = bus.ra2_d;
            rd1_e_d    = byp_rd1;
            rd2_e_d    = byp_rd2;
            wa3_e_d    = bus.wa3_d;
            extimm_e_d = bus.extimm_d;
            ctrl_e_d   = bus.valid_d ? bus.ctrl_d : CTRL_NOP;
        end
    end

    // Entry register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_e_q  <= 1'b0;
            ra1_e_q    <= '0;
            ra2_e_q    <= '0;
            rd1_e_q    <= '0;
            rd2_e_q    <= '0;
            wa3_e_q    <= '0;
            extimm_e_q <= '0;
            ctrl_e_q   <= CTRL_NOP;
            bubble_q   <= '0;
        end else begin
            valid_e_q  <= valid_e_d;
            ra1_e_q    <= ra1_e_d;
            ra2_e_q    <= ra2_e_d;
            rd1_e_q    <= rd1_e_d;
            rd2_e_q    <= rd2_e_d;
            wa3_e_q    <= wa3_e_d;
            extimm_e_q <= extimm_e_d;
            ctrl_e_q   <= ctrl_e_d;
            bubble_q   <= bubble_d;
        end
    end

    // Drive the execute-stage outputs straight from the registers.
    always_comb begin
        bus.valid_e    = valid_e_q;
        bus.ra1_e      = ra1_e_q;
        bus.ra2_e      = ra2_e_q;
        bus.rd1_e      = rd1_e_q;
        bus.rd2_e      = rd2_e_q;
        bus.wa3_e      = wa3_e_q;
        bus.extimm_e   = extimm_e_q;
        bus.ctrl_e     = ctrl_e_q;
        bus.bubble_cnt = bubble_q;
    end

endmodule
`default_nettype wire
